id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- ID/EX pipeline register directly upstream of the 32-bit EX-stage ALU.
- Captures decoded instruction fields and register-file data every cycle.
- Translates ALUOp/funct into the ALU's 4-bit ALUControl code and selects operands A/B.
- Drives the ALU combinationally from its registered outputs; supports hazard-unit stall (hold) and flush (bubble).

Parameters:
- DATA_W, 32, operand/data width
- REG_W, 5, register specifier width

Ports:
- Clk  in  1  rising-edge clock
- Reset  in  1  asynchronous, active-low reset
- Stall  in  1  hold all outputs this cycle
- Flush  in  1  load a bubble this cycle
- In_Valid  in  1  upstream instruction valid
- In_RegWrite, In_MemRead, In_MemWrite, In_MemToReg, In_Branch  in  1 each  decoded control
- In_ALUSrc  in  1  1 = B from immediate
- In_RegDst  in  1  1 = destination is Rd, 0 = Rt
- In_ALUOp  in  3  ALU class (encoding below)
- In_Funct  in  6  R-type funct field
- In_Shamt  in  5  shift amount
- In_ReadData1, In_ReadData2  in  DATA_W  register-file outputs
- In_Imm  in  DATA_W  sign/zero-extended immediate
- In_Rt, In_Rd  in  REG_W  register specifiers
- In_PCPlus4  in  32  PC+4
- Out_Valid  out  1  stage holds a real instruction
- ALUControl  out  4  to ALU
- ALU_A, ALU_B  out  DATA_W  to ALU
- Out_StoreData  out  DATA_W  registered In_ReadData2
- Out_WriteReg  out  REG_W  selected destination register
- Out_RegWrite, Out_MemRead, Out_MemWrite, Out_MemToReg, Out_Branch  out  1 each  registered control
- Out_PCPlus4  out  32  registered PC+4

Behaviour:
- All outputs are registered; latency is 1 cycle from input to output. There is no combinational path from inputs to outputs.
- Reset low (asynchronous): every output is 0. Out_Valid = 0 and ALUControl = 0.
- Update priority on each rising edge: Reset > Flush > Stall > load.
- Flush = 1 loads a bubble, including when Stall = 1 in the same cycle:
  - Out_Valid = 0; all Out_* control bits = 0.
  - ALUControl = 2 (add); ALU_A = ALU_B = Out_StoreData = 0; Out_WriteReg = 0.
- Stall = 1 (Flush = 0): every output holds its current value.
- Load with In_Valid = 0: identical to a bubble.
- Load with In_Valid = 1: capture all fields.
  - Out_WriteReg = In_RegDst ? In_Rd : In_Rt.
  - ALU_B = In_ALUSrc ? In_Imm : In_ReadData2.
  - ALU_A = In_ReadData1, except sll/srl, where ALU_A = {27'b0, In_Shamt} and ALU_B = In_ReadData2 (ALUSrc ignored).
- ALUControl codes: and 0, or 1, add 2, xor 3, sll 4, srl 5, sub 6, slt 7, nor 12, error 14, mul 15. Codes 8/9 (rotates) are reserved and never generated.
- In_ALUOp decode:
  - 000 add (lw/sw/addi); 001 sub (beq/bne)
  - 010 R-type, use funct; 011 and (andi); 100 or (ori)
  - 101 slt (slti); 110 xor (xori); 111 mul
- Funct decode (ALUOp = 010):
  - 0x20/0x21 add; 0x22/0x23 sub; 0x24 and; 0x25 or
  - 0x26 xor; 0x27 nor; 0x2A slt; 0x00 sll; 0x02 srl
  - any other funct → add with Out_RegWrite forced 0 (treated as nop)
- Funct 0x00 with In_Rd = 0 (canonical nop) decodes as sll with RegWrite as given. A write to $0 is the downstream stage's concern.
- A mid-operation reset clears the stage immediately. The first load after Reset deasserts happens on the next rising edge.

Optional Feature:
- Macro: ID_EX_ILLEGAL_TRAP_EN.
- Defined:
  - Undefined funct yields ALUControl = 14 and Out_RegWrite = 0.
  - Adds output port Illegal (1 bit), a sticky flag set on any loaded valid instruction with undefined funct.
  - Illegal is cleared only by Reset; Flush does not clear it.
- Not defined: no Illegal port; undefined funct behaves as the add-nop described above.

Test Plan:
- Reset low mid-stream, with a valid instruction loaded → all outputs 0 within the same cycle, asynchronously. After release, the next edge loads normally.
- R-type add: ALUOp = 010, funct = 0x20, RD1 = 5, RD2 = 7, RegDst = 1, Rd = 9 → next cycle ALUControl = 2, A = 5, B = 7, Out_WriteReg = 9, Out_Valid = 1.
- addi: ALUSrc = 1, ALUOp = 000, Imm = 0xFFFFFFFC, RD1 = 0x10, Rt = 4 → A = 0x10, B = 0xFFFFFFFC, WriteReg = 4, ALUControl = 2.
- sll: funct = 0x00, Shamt = 3, RD2 = 0x1 → ALUControl = 4, A = 3, B = 1. Separately, nor: funct = 0x27 → ALUControl = 12.
- Stall and flush priority:
  - Stall = 1 for 3 cycles while the inputs change → outputs unchanged.
  - Stall = 1 with Flush = 1 → bubble: Out_Valid = 0, RegWrite = MemWrite = Branch = 0, ALUControl = 2.
- Undefined funct 0x3F with RegWrite = 1:
  - Macro off → ALUControl = 2, Out_RegWrite = 0.
  - Macro on → ALUControl = 14; Illegal stays 1 across subsequent flushes until Reset.

Source files
------------

// File: rtl/id_ex_stage.sv
// ============================================================================
// Module  : id_ex_stage
// Brief   : ID/EX pipeline register. Decodes ALUOp/funct into ALUControl and
//           selects ALU operands. Optional macro ID_EX_ILLEGAL_TRAP_EN adds a
//           sticky Illegal flag and an error code for undefined funct.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Stall,
  input  logic              Flush,
  input  logic              In_Valid,
  input  logic              In_RegWrite,
  input  logic              In_MemRead,
  input  logic              In_MemWrite,
  input  logic              In_MemToReg,
  input  logic              In_Branch,
  input  logic              In_ALUSrc,
  input  logic              In_RegDst,
  input  logic [2:0]        In_ALUOp,
  input  logic [5:0]        In_Funct,
  input  logic [4:0]        In_Shamt,
  input  logic [DATA_W-1:0] In_ReadData1,
  input  logic [DATA_W-1:0] In_ReadData2,
  input  logic [DATA_W-1:0] In_Imm,
  input  logic [REG_W-1:0]  In_Rt,
  input  logic [REG_W-1:0]  In_Rd,
  input  logic [31:0]       In_PCPlus4,
`ifdef ID_EX_ILLEGAL_TRAP_EN
  output logic              Illegal,
`endif
  output logic              Out_Valid,
  output logic [3:0]        ALUControl,
  output logic [DATA_W-1:0] ALU_A,
  output logic [DATA_W-1:0] ALU_B,
  output logic [DATA_W-1:0] Out_StoreData,
  output logic [REG_W-1:0]  Out_WriteReg,
  output logic              Out_RegWrite,
  output logic              Out_MemRead,
  output logic              Out_MemWrite,
  output logic              Out_MemToReg,
  output logic              Out_Branch,
  output logic [31:0]       Out_PCPlus4
);

  localparam logic [3:0] ALU_AND = 4'd0;
  localparam logic [3:0] ALU_OR  = 4'd1;
  localparam logic [3:0] ALU_ADD = 4'd2;
  localparam logic [3:0] ALU_XOR = 4'd3;
  localparam logic [3:0] ALU_SLL = 4'd4;
  localparam logic [3:0] ALU_SRL = 4'd5;
  localparam logic [3:0] ALU_SUB = 4'd6;
  localparam logic [3:0] ALU_SLT = 4'd7;
  localparam logic [3:0] ALU_NOR = 4'd12;
  localparam logic [3:0] ALU_ERR = 4'd14;
  localparam logic [3:0] ALU_MUL = 4'd15;

  logic [3:0]        funct_ctrl;
  logic              funct_shift;
  logic              funct_undef;
  logic [3:0]        alu_ctrl;
  logic              is_shift;
  logic              is_undef;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic              bubble;
  logic              load;

  always_comb begin
    funct_ctrl  = ALU_ADD;
    funct_shift = 1'b0;
    funct_undef = 1'b0;
    case (In_Funct)
      6'h20, 6'h21: funct_ctrl = ALU_ADD;
      6'h22, 6'h23: funct_ctrl = ALU_SUB;
      6'h24:        funct_ctrl = ALU_AND;
      6'h25:        funct_ctrl = ALU_OR;
      6'h26:        funct_ctrl = ALU_XOR;
      6'h27:        funct_ctrl = ALU_NOR;
      6'h2A:        funct_ctrl = ALU_SLT;
      6'h00: begin funct_ctrl = ALU_SLL; funct_shift = 1'b1; end
      6'h02: begin funct_ctrl = ALU_SRL; funct_shift = 1'b1; end
      default: begin
        funct_undef = 1'b1;
`ifdef ID_EX_ILLEGAL_TRAP_EN
        funct_ctrl  = ALU_ERR;
`else
        funct_ctrl  = ALU_ADD;
`endif
      end
    endcase

    case (In_ALUOp)
      3'b000:  alu_ctrl = ALU_ADD;
      3'b001:  alu_ctrl = ALU_SUB;
      3'b010:  alu_ctrl = funct_ctrl;
      3'b011:  alu_ctrl = ALU_AND;
      3'b100:  alu_ctrl = ALU_OR;
      3'b101:  alu_ctrl = ALU_SLT;
      3'b110:  alu_ctrl = ALU_XOR;
      default: alu_ctrl = ALU_MUL;
    endcase

    is_shift = (In_ALUOp == 3'b010) && funct_shift;
    is_undef = (In_ALUOp == 3'b010) && funct_undef;
    // Shifts take the amount on A and the shifted value on B, regardless of ALUSrc
    op_a = is_shift ? {{(DATA_W-5){1'b0}}, In_Shamt} : In_ReadData1;
    op_b = (In_ALUSrc && !is_shift) ? In_Imm : In_ReadData2;

    bubble = Flush || (!Stall && !In_Valid);
    load   = !Flush && !Stall && In_Valid;
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      Out_Valid     <= 1'b0;
      ALUControl    <= 4'd0;
      ALU_A         <= '0;
      ALU_B         <= '0;
      Out_StoreData <= '0;
      Out_WriteReg  <= '0;
      Out_RegWrite  <= 1'b0;
      Out_MemRead   <= 1'b0;
      Out_MemWrite  <= 1'b0;
      Out_MemToReg  <= 1'b0;
      Out_Branch    <= 1'b0;
      Out_PCPlus4   <= 32'd0;
    end else if (bubble) begin
      Out_Valid     <= 1'b0;
      ALUControl    <= ALU_ADD;
      ALU_A         <= '0;
      ALU_B         <= '0;
      Out_StoreData <= '0;
      Out_WriteReg  <= '0;
      Out_RegWrite  <= 1'b0;
      Out_MemRead   <= 1'b0;
      Out_MemWrite  <= 1'b0;
      Out_MemToReg  <= 1'b0;
      Out_Branch    <= 1'b0;
      Out_PCPlus4   <= 32'd0;
    end else if (load) begin
      Out_Valid     <= 1'b1;
      ALUControl    <= alu_ctrl;
      ALU_A         <= op_a;
      ALU_B         <= op_b;
      Out_StoreData <= In_ReadData2;
      Out_WriteReg  <= In_RegDst ? In_Rd : In_Rt;
      Out_RegWrite  <= In_RegWrite && !is_undef;
      Out_MemRead   <= In_MemRead;
      Out_MemWrite  <= In_MemWrite;
      Out_MemToReg  <= In_MemToReg;
      Out_Branch    <= In_Branch;
      Out_PCPlus4   <= In_PCPlus4;
    end
  end

`ifdef ID_EX_ILLEGAL_TRAP_EN
  // Sticky until reset; flushes deliberately leave it set
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      Illegal <= 1'b0;
    end else if (load && is_undef) begin
      Illegal <= 1'b1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_id_ex_stage.sv
// ============================================================================
// Module  : tb_id_ex_stage
// Brief   : Self-checking bench for id_ex_stage against a behavioural model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_id_ex_stage;

  typedef struct packed {
    logic        valid;
    logic        rw, mr, mw, m2r, br;
    logic        alusrc, regdst;
    logic [2:0]  aluop;
    logic [5:0]  funct;
    logic [4:0]  shamt;
    logic [31:0] rd1, rd2, imm;
    logic [4:0]  rt, rd;
    logic [31:0] pc;
  } tx_t;

  typedef struct packed {
    logic        valid;
    logic [3:0]  aluc;
    logic [31:0] a, b, sd;
    logic [4:0]  wr;
    logic        rw, mr, mw, m2r, br;
    logic [31:0] pc;
  } out_t;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        Stall = 1'b0, Flush = 1'b0;
  logic        In_Valid = 1'b0;
  logic        In_RegWrite = 1'b0, In_MemRead = 1'b0, In_MemWrite = 1'b0;
  logic        In_MemToReg = 1'b0, In_Branch = 1'b0, In_ALUSrc = 1'b0, In_RegDst = 1'b0;
  logic [2:0]  In_ALUOp = '0;
  logic [5:0]  In_Funct = '0;
  logic [4:0]  In_Shamt = '0;
  logic [31:0] In_ReadData1 = '0, In_ReadData2 = '0, In_Imm = '0, In_PCPlus4 = '0;
  logic [4:0]  In_Rt = '0, In_Rd = '0;

  logic        Out_Valid;
  logic [3:0]  ALUControl;
  logic [31:0] ALU_A, ALU_B, Out_StoreData, Out_PCPlus4;
  logic [4:0]  Out_WriteReg;
  logic        Out_RegWrite, Out_MemRead, Out_MemWrite, Out_MemToReg, Out_Branch;
`ifdef ID_EX_ILLEGAL_TRAP_EN
  logic        Illegal;
`endif

  int   n_checks = 0;
  int   n_fail   = 0;
  out_t exp_out;
  logic exp_illegal;

  id_ex_stage #(.DATA_W(32), .REG_W(5)) dut (
    .Clk(Clk), .Reset(Reset), .Stall(Stall), .Flush(Flush), .In_Valid(In_Valid),
    .In_RegWrite(In_RegWrite), .In_MemRead(In_MemRead), .In_MemWrite(In_MemWrite),
    .In_MemToReg(In_MemToReg), .In_Branch(In_Branch), .In_ALUSrc(In_ALUSrc),
    .In_RegDst(In_RegDst), .In_ALUOp(In_ALUOp), .In_Funct(In_Funct), .In_Shamt(In_Shamt),
    .In_ReadData1(In_ReadData1), .In_ReadData2(In_ReadData2), .In_Imm(In_Imm),
    .In_Rt(In_Rt), .In_Rd(In_Rd), .In_PCPlus4(In_PCPlus4),
`ifdef ID_EX_ILLEGAL_TRAP_EN
    .Illegal(Illegal),
`endif
    .Out_Valid(Out_Valid), .ALUControl(ALUControl), .ALU_A(ALU_A), .ALU_B(ALU_B),
    .Out_StoreData(Out_StoreData), .Out_WriteReg(Out_WriteReg),
    .Out_RegWrite(Out_RegWrite), .Out_MemRead(Out_MemRead), .Out_MemWrite(Out_MemWrite),
    .Out_MemToReg(Out_MemToReg), .Out_Branch(Out_Branch), .Out_PCPlus4(Out_PCPlus4)
  );

  always #5 Clk = ~Clk;

  function automatic out_t get_obs();
    out_t o;
    o = '{valid: Out_Valid, aluc: ALUControl, a: ALU_A, b: ALU_B, sd: Out_StoreData,
          wr: Out_WriteReg, rw: Out_RegWrite, mr: Out_MemRead, mw: Out_MemWrite,
          m2r: Out_MemToReg, br: Out_Branch, pc: Out_PCPlus4};
    return o;
  endfunction

  function automatic out_t bubble_out();
    out_t o = '0;
    o.aluc = 4'd2;
    return o;
  endfunction

  // Undefined R-type funct: anything outside the documented set
  function automatic bit funct_undefined(input logic [5:0] f);
    return !(f inside {6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                       6'h2A, 6'h00, 6'h02});
  endfunction

  function automatic out_t predict(input tx_t t);
    out_t o;
    bit   rtype, shift, undef;
    int   code;
    if (!t.valid) return bubble_out();
    rtype = (t.aluop == 3'd2);
    undef = rtype && funct_undefined(t.funct);
    shift = rtype && (t.funct == 6'h00 || t.funct == 6'h02);
    case (t.aluop)
      3'd0: code = 2;
      3'd1: code = 6;
      3'd3: code = 0;
      3'd4: code = 1;
      3'd5: code = 7;
      3'd6: code = 3;
      3'd7: code = 15;
      default: begin
        if (t.funct == 6'h20 || t.funct == 6'h21) code = 2;
        else if (t.funct == 6'h22 || t.funct == 6'h23) code = 6;
        else if (t.funct == 6'h24) code = 0;
        else if (t.funct == 6'h25) code = 1;
        else if (t.funct == 6'h26) code = 3;
        else if (t.funct == 6'h27) code = 12;
        else if (t.funct == 6'h2A) code = 7;
        else if (t.funct == 6'h00) code = 4;
        else if (t.funct == 6'h02) code = 5;
`ifdef ID_EX_ILLEGAL_TRAP_EN
        else code = 14;
`else
        else code = 2;
`endif
      end
    endcase
    o.valid = 1'b1;
    o.aluc  = code[3:0];
    o.a     = shift ? 32'(t.shamt) : t.rd1;
    o.b     = shift ? t.rd2 : (t.alusrc ? t.imm : t.rd2);
    o.sd    = t.rd2;
    o.wr    = t.regdst ? t.rd : t.rt;
    o.rw    = t.rw && !undef;
    o.mr    = t.mr;
    o.mw    = t.mw;
    o.m2r   = t.m2r;
    o.br    = t.br;
    o.pc    = t.pc;
    return o;
  endfunction

  task automatic drive(input tx_t t);
    In_Valid = t.valid; In_RegWrite = t.rw; In_MemRead = t.mr; In_MemWrite = t.mw;
    In_MemToReg = t.m2r; In_Branch = t.br; In_ALUSrc = t.alusrc; In_RegDst = t.regdst;
    In_ALUOp = t.aluop; In_Funct = t.funct; In_Shamt = t.shamt;
    In_ReadData1 = t.rd1; In_ReadData2 = t.rd2; In_Imm = t.imm;
    In_Rt = t.rt; In_Rd = t.rd; In_PCPlus4 = t.pc;
  endtask

  function automatic tx_t rand_tx();
    tx_t t;
    logic [5:0] fl [12] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26,
                            6'h27, 6'h2A, 6'h00, 6'h02, 6'h3F};
    t = '{valid: ($urandom_range(0, 7) != 0), rw: 1'($urandom), mr: 1'($urandom),
          mw: 1'($urandom), m2r: 1'($urandom), br: 1'($urandom), alusrc: 1'($urandom),
          regdst: 1'($urandom), aluop: 3'($urandom), funct: 6'($urandom),
          shamt: 5'($urandom), rd1: $urandom, rd2: $urandom, imm: $urandom,
          rt: 5'($urandom), rd: 5'($urandom), pc: $urandom};
    if ($urandom_range(0, 3) != 0) t.funct = fl[$urandom_range(0, 11)];
    return t;
  endfunction

  // One clock: apply controls and inputs, advance the model, sample after the edge
  task automatic step(input logic fl, input logic st, input tx_t t);
    Flush = fl;
    Stall = st;
    drive(t);
    if (fl) exp_out = bubble_out();
    else if (!st) begin
      exp_out = predict(t);
      if (t.valid && t.aluop == 3'd2 && funct_undefined(t.funct)) exp_illegal = 1'b1;
    end
    @(posedge Clk);
    #1;
  endtask

  function automatic tx_t base_tx();
    tx_t t = '0;
    t.valid = 1'b1;
    t.pc    = 32'h0000_1004;
    return t;
  endfunction

  task automatic test_reset();
    out_t o;
    #2 Reset = 1'b0;
    #1;
    exp_out = '0;
    exp_illegal = 1'b0;
    o = get_obs();
    n_checks++;
    if (o !== 143'd0) begin
      n_fail++;
      $display("FAIL reset_state: got %h expected all zero", o);
    end
    @(posedge Clk); #1;
    Reset = 1'b1;
  endtask

  task automatic test_rtype_add();
    tx_t t = base_tx();
    out_t o;
    t.aluop = 3'd2; t.funct = 6'h20; t.rd1 = 32'd5; t.rd2 = 32'd7;
    t.regdst = 1'b1; t.rd = 5'd9; t.rt = 5'd3; t.rw = 1'b1;
    step(1'b0, 1'b0, t);
    o = get_obs();
    n_checks++;
    if (o.aluc !== 4'd2 || o.a !== 32'd5 || o.b !== 32'd7 || o.wr !== 5'd9 ||
        o.valid !== 1'b1 || o.rw !== 1'b1) begin
      n_fail++;
      $display("FAIL rtype_add: got aluc=%0d a=%0d b=%0d wr=%0d v=%0b rw=%0b, expected 2/5/7/9/1/1",
               o.aluc, o.a, o.b, o.wr, o.valid, o.rw);
    end
  endtask

  task automatic test_addi();
    tx_t t = base_tx();
    out_t o;
    t.aluop = 3'd0; t.alusrc = 1'b1; t.imm = 32'hFFFF_FFFC; t.rd1 = 32'h10;
    t.rd2 = 32'h55; t.rt = 5'd4; t.rd = 5'd17; t.rw = 1'b1;
    step(1'b0, 1'b0, t);
    o = get_obs();
    n_checks++;
    if (o.a !== 32'h10 || o.b !== 32'hFFFF_FFFC || o.wr !== 5'd4 || o.aluc !== 4'd2 ||
        o.sd !== 32'h55) begin
      n_fail++;
      $display("FAIL addi: got a=%h b=%h wr=%0d aluc=%0d sd=%h, expected 10/fffffffc/4/2/55",
               o.a, o.b, o.wr, o.aluc, o.sd);
    end
  endtask

  task automatic test_shift_nor();
    tx_t t = base_tx();
    out_t o;
    t.aluop = 3'd2; t.funct = 6'h00; t.shamt = 5'd3; t.rd1 = 32'hDEAD;
    t.rd2 = 32'h1; t.alusrc = 1'b1; t.imm = 32'h77; t.rw = 1'b1;
    step(1'b0, 1'b0, t);
    o = get_obs();
    n_checks++;
    if (o.aluc !== 4'd4 || o.a !== 32'd3 || o.b !== 32'd1 || o.rw !== 1'b1) begin
      n_fail++;
      $display("FAIL sll: got aluc=%0d a=%h b=%h rw=%0b, expected 4/3/1/1", o.aluc, o.a, o.b, o.rw);
    end
    t.funct = 6'h02; t.shamt = 5'd31; t.rd2 = 32'h8000_0000;
    step(1'b0, 1'b0, t);
    o = get_obs();
    n_checks++;
    if (o.aluc !== 4'd5 || o.a !== 32'd31 || o.b !== 32'h8000_0000) begin
      n_fail++;
      $display("FAIL srl: got aluc=%0d a=%h b=%h, expected 5/1f/80000000", o.aluc, o.a, o.b);
    end
    t.funct = 6'h27; t.alusrc = 1'b0; t.rd1 = 32'hF0; t.rd2 = 32'h0F;
    step(1'b0, 1'b0, t);
    o = get_obs();
    n_checks++;
    if (o.aluc !== 4'd12 || o.a !== 32'hF0 || o.b !== 32'h0F) begin
      n_fail++;
      $display("FAIL nor: got aluc=%0d a=%h b=%h, expected 12/f0/0f", o.aluc, o.a, o.b);
    end
  endtask

  task automatic test_stall_flush();
    tx_t t = base_tx();
    out_t held, o;
    t.aluop = 3'd7; t.rd1 = 32'h1234; t.rd2 = 32'h5678; t.rw = 1'b1; t.mw = 1'b1; t.br = 1'b1;
    step(1'b0, 1'b0, t);
    held = get_obs();
    n_checks++;
    if (held.aluc !== 4'd15 || held.valid !== 1'b1) begin
      n_fail++;
      $display("FAIL mul_load: got aluc=%0d v=%0b, expected 15/1", held.aluc, held.valid);
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, rand_tx());
      o = get_obs();
      n_checks++;
      if (o !== held) begin
        n_fail++;
        $display("FAIL stall_hold%0d: got %h expected %h", i, o, held);
      end
    end
    step(1'b1, 1'b1, t);
    o = get_obs();
    n_checks++;
    if (o.valid !== 1'b0 || o.rw !== 1'b0 || o.mw !== 1'b0 || o.br !== 1'b0 ||
        o.aluc !== 4'd2 || o.a !== 32'd0 || o.b !== 32'd0 || o.sd !== 32'd0 || o.wr !== 5'd0) begin
      n_fail++;
      $display("FAIL stall_flush_bubble: got %h expected bubble", o);
    end
    t.valid = 1'b0;
    step(1'b0, 1'b0, t);
    o = get_obs();
    n_checks++;
    if (o !== exp_out) begin
      n_fail++;
      $display("FAIL invalid_load: got %h expected %h", o, exp_out);
    end
  endtask

  task automatic test_undefined_funct();
    tx_t t = base_tx();
    out_t o;
    t.aluop = 3'd2; t.funct = 6'h3F; t.rw = 1'b1; t.rd1 = 32'h9; t.rd2 = 32'hA;
    step(1'b0, 1'b0, t);
    o = get_obs();
    n_checks++;
`ifdef ID_EX_ILLEGAL_TRAP_EN
    if (o.aluc !== 4'd14 || o.rw !== 1'b0 || Illegal !== 1'b1) begin
      n_fail++;
      $display("FAIL undef_funct: got aluc=%0d rw=%0b ill=%0b, expected 14/0/1", o.aluc, o.rw, Illegal);
    end
    step(1'b1, 1'b0, t);
    step(1'b1, 1'b0, t);
    n_checks++;
    if (Illegal !== 1'b1) begin
      n_fail++;
      $display("FAIL illegal_sticky: got %0b expected 1", Illegal);
    end
`else
    if (o.aluc !== 4'd2 || o.rw !== 1'b0 || o.valid !== 1'b1) begin
      n_fail++;
      $display("FAIL undef_funct: got aluc=%0d rw=%0b v=%0b, expected 2/0/1", o.aluc, o.rw, o.valid);
    end
`endif
  endtask

  task automatic test_random();
    out_t o;
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 9) == 0), ($urandom_range(0, 4) == 0), rand_tx());
      o = get_obs();
      n_checks++;
      if (o !== exp_out) begin
        n_fail++;
        $display("FAIL random%0d: got %h expected %h", i, o, exp_out);
      end
`ifdef ID_EX_ILLEGAL_TRAP_EN
      n_checks++;
      if (Illegal !== exp_illegal) begin
        n_fail++;
        $display("FAIL random_illegal%0d: got %0b expected %0b", i, Illegal, exp_illegal);
      end
`endif
    end
  endtask

  task automatic test_async_reset();
    tx_t t = base_tx();
    out_t o;
    t.aluop = 3'd1; t.rd1 = 32'hAA; t.rd2 = 32'hBB; t.rw = 1'b1; t.br = 1'b1;
    step(1'b0, 1'b0, t);
    #2 Reset = 1'b0;
    #1;
    o = get_obs();
    n_checks++;
    if (o !== 143'd0) begin
      n_fail++;
      $display("FAIL async_reset: got %h expected all zero", o);
    end
`ifdef ID_EX_ILLEGAL_TRAP_EN
    n_checks++;
    if (Illegal !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_illegal: got %0b expected 0", Illegal);
    end
`endif
    exp_out = '0;
    exp_illegal = 1'b0;
    #1 Reset = 1'b1;
    t.aluop = 3'd5; t.rd1 = 32'h3;
    step(1'b0, 1'b0, t);
    o = get_obs();
    n_checks++;
    if (o !== exp_out || o.aluc !== 4'd7 || o.valid !== 1'b1) begin
      n_fail++;
      $display("FAIL post_reset_load: got %h expected %h", o, exp_out);
    end
  endtask

  initial begin
    exp_out = '0;
    exp_illegal = 1'b0;
    test_reset();
    test_rtype_add();
    test_addi();
    test_shift_nor();
    test_stall_flush();
    test_undefined_funct();
    test_random();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
